// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, BCD limit and default tick rate for the countdown timer.
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int DEF_TICKS_PER_SEC = 50_000_000;
  function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one loadable BCD digit that counts down and wraps 0 -> 9 with a borrow.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic       fastclock,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       borrow_out
);
  assign borrow_out = en & (digit == 4'd0);
  always_ff @(posedge fastclock)
    if (reset) digit <= 4'd0;
    else if (load) digit <= load_val;
    else if (en) digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: two-digit BCD countdown with 1 s prescaler, pause/resume and expiry flag.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int PRESC_W = 26
) (
  input  logic       fastclock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done,
  output logic       expire,
  output logic       tick
);
  localparam logic [PRESC_W-1:0] RELOAD = PRESC_W'(TICKS_PER_SEC - 1);
  state_t state;
  logic [PRESC_W-1:0] presc;
  logic ld, dec, last, ones_borrow, tens_borrow;
  // pause beats a pending tick, so the prescaler stays at 0 and fires right after resume
  assign ld = load & (state != RUN);
  assign dec = (state == RUN) & (presc == '0) & ~pause;
  assign last = dec & (tens == 4'd0) & (ones == 4'd1);
  assign running = (state == RUN);
  assign done = (state == EXPIRED);
  bcd_down_digit u_ones (
    .fastclock(fastclock), .reset(reset), .en(dec), .load(ld),
    .load_val(bcd_clamp(load_ones)), .digit(ones), .borrow_out(ones_borrow)
  );
  bcd_down_digit u_tens (
    .fastclock(fastclock), .reset(reset), .en(ones_borrow), .load(ld),
    .load_val(bcd_clamp(load_tens)), .digit(tens), .borrow_out(tens_borrow)
  );
  always_ff @(posedge fastclock)
    if (reset) begin
      state <= IDLE;
      presc <= RELOAD;
      tick <= 1'b0;
      expire <= 1'b0;
    end else begin
      tick <= dec;
      expire <= last;
      if (ld) begin
        state <= IDLE;
        presc <= RELOAD;
      end else
        case (state)
          IDLE: if (start && (tens != 4'd0 || ones != 4'd0)) begin
            state <= RUN;
            presc <= RELOAD;
          end
          RUN: if (pause) state <= PAUSED;
          else begin
            presc <= (presc == '0) ? RELOAD : presc - 1'b1;
            if (last) state <= EXPIRED;
          end
          PAUSED: if (!pause && start) state <= RUN;
          default: ;
        endcase
    end
  logic unused;
  assign unused = tens_borrow;
endmodule
